// File: rtl/radix_4_div_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// radix_4_div_ctrl
//
// Sequencing controller for a radix-4 SRT divider datapath. A request is
// accepted in IDLE. The controller then moves through these steps:
//   - PRE_0: normalisation; the early-out decision is taken here.
//   - PRE_1: operand setup.
//   - ITER:  one cycle per quotient digit pair.
//   - POST_0, POST_1: remainder fix-up and quotient correction.
//   - DONE:  the result is held until the consumer accepts it.
// The controller also keeps the previous quotient digit, which the QDS
// needs for its next selection.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   start_valid_i/_ready_o request handshake (ready only in IDLE)
//   flush_i               synchronous abort back to IDLE
//   dividend_lzc_i        leading-zero count of the dividend (sampled in PRE_0)
//   divisor_lzc_i         leading-zero count of the divisor (sampled in PRE_0)
//   divisor_zero_i        divisor is zero (sampled in PRE_0)
//   quot_digit_i          one-hot QDS digit {+2,+1,0,-1,-2} (used in ITER)
//   prev_quot_digit_o     registered previous digit back to the QDS
//   *_en_o                datapath stage enables, one per working state
//   odd_shift_o           normalisation needs one extra bit of shift
//   iter_cnt_o            iterations remaining after the current one
//   early_finish_o        result produced without iterating
//   div_by_zero_o         divisor was zero
//   finish_valid_o/_ready_i result handshake (valid only in DONE)
// ---------------------------------------------------------------------------
module radix_4_div_ctrl #(
  parameter int WIDTH = 32,
  parameter int LZC_W = $clog2(WIDTH),
  parameter int CNT_W = $clog2(WIDTH / 2 + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid_i,
  output logic             start_ready_o,
  input  logic             flush_i,
  input  logic [LZC_W-1:0] dividend_lzc_i,
  input  logic [LZC_W-1:0] divisor_lzc_i,
  input  logic             divisor_zero_i,
  input  logic [4:0]       quot_digit_i,
  output logic [4:0]       prev_quot_digit_o,
  output logic             pre_0_en_o,
  output logic             pre_1_en_o,
  output logic             iter_en_o,
  output logic             post_0_en_o,
  output logic             post_1_en_o,
  output logic             odd_shift_o,
  output logic [CNT_W-1:0] iter_cnt_o,
  output logic             early_finish_o,
  output logic             div_by_zero_o,
  output logic             finish_valid_o,
  input  logic             finish_ready_i
);

  typedef enum logic [6:0] {
    IDLE   = 7'b0000001,
    PRE_0  = 7'b0000010,
    PRE_1  = 7'b0000100,
    ITER   = 7'b0001000,
    POST_0 = 7'b0010000,
    POST_1 = 7'b0100000,
    DONE   = 7'b1000000
  } state_e;

  // One-hot encoding of the "0" digit; the QDS starts every run from it.
  localparam logic [4:0] DIGIT_ZERO = 5'b00100;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       digit_q, digit_d;
  logic             odd_q, odd_d;
  logic             early_q, early_d;
  logic             dbz_q, dbz_d;

  // One extra bit of width keeps the subtraction from wrapping; the early-out
  // check covers the case where the result would be negative.
  logic [LZC_W:0]   lzc_diff;
  logic             early_out;
  logic [CNT_W-1:0] cnt_load;

  assign lzc_diff  = {1'b0, divisor_lzc_i} - {1'b0, dividend_lzc_i};
  assign early_out = divisor_zero_i | (dividend_lzc_i > divisor_lzc_i);
  // Each radix-4 iteration retires two bits, so (diff >> 1) + 1 iterations.
  assign cnt_load  = CNT_W'(lzc_diff >> 1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    digit_d = digit_q;
    odd_d   = odd_q;
    early_d = early_q;
    dbz_d   = dbz_q;

    if (flush_i) begin
      // Abort wins over every handshake in the same cycle.
      state_d = IDLE;
      cnt_d   = '0;
      digit_d = DIGIT_ZERO;
      odd_d   = 1'b0;
      early_d = 1'b0;
      dbz_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_valid_i) begin
            state_d = PRE_0;
            odd_d   = 1'b0;
            early_d = 1'b0;
            dbz_d   = 1'b0;
          end
        end
        PRE_0: begin
          if (early_out) begin
            state_d = DONE;
            early_d = 1'b1;
            dbz_d   = divisor_zero_i;
          end else begin
            state_d = PRE_1;
            odd_d   = lzc_diff[0];
            cnt_d   = cnt_load;
          end
        end
        PRE_1: begin
          state_d = ITER;
          digit_d = DIGIT_ZERO;
        end
        ITER: begin
          // Digit is taken as-is; a malformed code is the QDS's problem.
          digit_d = quot_digit_i;
          if (cnt_q == '0) begin
            state_d = POST_0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        POST_0: state_d = POST_1;
        POST_1: state_d = DONE;
        DONE: begin
          if (finish_ready_i) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      digit_q <= DIGIT_ZERO;
      odd_q   <= 1'b0;
      early_q <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
      odd_q   <= odd_d;
      early_q <= early_d;
      dbz_q   <= dbz_d;
    end
  end

  // Pure decodes of the state register: no input reaches these outputs.
  assign start_ready_o     = (state_q == IDLE);
  assign pre_0_en_o        = (state_q == PRE_0);
  assign pre_1_en_o        = (state_q == PRE_1);
  assign iter_en_o         = (state_q == ITER);
  assign post_0_en_o       = (state_q == POST_0);
  assign post_1_en_o       = (state_q == POST_1);
  assign finish_valid_o    = (state_q == DONE);

  assign prev_quot_digit_o = digit_q;
  assign iter_cnt_o        = cnt_q;
  assign odd_shift_o       = odd_q;
  assign early_finish_o    = early_q;
  assign div_by_zero_o     = dbz_q;

endmodule

// File: tb/tb_radix_4_div_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for radix_4_div_ctrl: the stimulus process predicts each
// operation's outcome from the lzc arithmetic and queues it; a monitor on the
// falling edge compares the DUT against those predictions and protocol rules.
module tb_radix_4_div_ctrl;

  localparam int WIDTH = 32;
  localparam int LZC_W = 5;
  localparam int CNT_W = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             start_valid_i;
  logic             start_ready_o;
  logic             flush_i;
  logic [LZC_W-1:0] dividend_lzc_i;
  logic [LZC_W-1:0] divisor_lzc_i;
  logic             divisor_zero_i;
  logic [4:0]       quot_digit_i;
  logic [4:0]       prev_quot_digit_o;
  logic             pre_0_en_o, pre_1_en_o, iter_en_o, post_0_en_o, post_1_en_o;
  logic             odd_shift_o;
  logic [CNT_W-1:0] iter_cnt_o;
  logic             early_finish_o;
  logic             div_by_zero_o;
  logic             finish_valid_o;
  logic             finish_ready_i;

  radix_4_div_ctrl #(.WIDTH(WIDTH), .LZC_W(LZC_W), .CNT_W(CNT_W)) dut (
    .clk               (clk),
    .rst               (rst),
    .start_valid_i     (start_valid_i),
    .start_ready_o     (start_ready_o),
    .flush_i           (flush_i),
    .dividend_lzc_i    (dividend_lzc_i),
    .divisor_lzc_i     (divisor_lzc_i),
    .divisor_zero_i    (divisor_zero_i),
    .quot_digit_i      (quot_digit_i),
    .prev_quot_digit_o (prev_quot_digit_o),
    .pre_0_en_o        (pre_0_en_o),
    .pre_1_en_o        (pre_1_en_o),
    .iter_en_o         (iter_en_o),
    .post_0_en_o       (post_0_en_o),
    .post_1_en_o       (post_1_en_o),
    .odd_shift_o       (odd_shift_o),
    .iter_cnt_o        (iter_cnt_o),
    .early_finish_o    (early_finish_o),
    .div_by_zero_o     (div_by_zero_o),
    .finish_valid_o    (finish_valid_o),
    .finish_ready_i    (finish_ready_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int lat;
    int iters;
    int early;
    int dbz;
    int odd;
  } exp_t;

  exp_t       exp_q[$];
  logic [4:0] dig_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Reference: outcome of one request from the lzc arithmetic alone.
  function automatic exp_t model(input int dvd, input int dvs, input bit dz);
    exp_t e;
    int   diff;
    diff    = dvs - dvd;
    e.early = (dz || dvd > dvs) ? 1 : 0;
    e.dbz   = dz ? 1 : 0;
    e.iters = e.early ? 0 : diff / 2 + 1;
    e.odd   = e.early ? 0 : diff % 2;
    e.lat   = e.early ? 2 : e.iters + 5;
    return e;
  endfunction

  function automatic logic [4:0] rnd_digit();
    if ($urandom_range(0, 3) != 0) return 5'b00001 << $urandom_range(0, 4);
    return 5'($urandom);
  endfunction

  task automatic check_reset_state(input string nm);
    chk({nm, "_state"}, {start_ready_o, pre_0_en_o, pre_1_en_o, iter_en_o,
                         post_0_en_o, post_1_en_o, finish_valid_o}, 7'b1000000);
    chk({nm, "_prev_digit"}, prev_quot_digit_o, 5'b00100);
    chk({nm, "_iter_cnt"}, iter_cnt_o, 0);
    chk({nm, "_flags"}, {odd_shift_o, early_finish_o, div_by_zero_o}, 3'b000);
  endtask

  // ---------------------------------------------------------------- monitor
  initial begin : monitor
    bit               p_valid, p_flush, p_fv, p_fready, p_iter;
    logic [CNT_W-1:0] p_cnt, first_cnt, e_cnt;
    bit               in_op;
    int               hs_cyc, iter_seen, op_idx;
    exp_t             e;
    p_valid = 0; in_op = 0; op_idx = 0; first_cnt = '0;
    hs_cyc = 0; iter_seen = 0;
    p_flush = 0; p_fv = 0; p_fready = 0; p_iter = 0; p_cnt = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        p_valid = 0;
        in_op   = 0;
        continue;
      end
      chk("state_onehot", $countones({start_ready_o, pre_0_en_o, pre_1_en_o, iter_en_o,
                                      post_0_en_o, post_1_en_o, finish_valid_o}), 1);
      if (p_valid) begin
        if (p_flush) begin
          chk("flush_idle", {start_ready_o, pre_0_en_o, finish_valid_o,
                             odd_shift_o, early_finish_o, div_by_zero_o}, 6'b100000);
          in_op = 0;
        end else begin
          if (p_fv && !p_fready) chk("done_hold", {finish_valid_o, start_ready_o}, 2'b10);
          if (p_fv && p_fready)  chk("done_exit", {finish_valid_o, start_ready_o}, 2'b01);
          if (p_iter) begin
            if (dig_q.size() == 0) chk("prev_digit_unexpected", 1, 0);
            else                   chk("prev_digit", prev_quot_digit_o, dig_q.pop_front());
            if (iter_en_o) begin
              e_cnt = p_cnt - 1'b1;
              chk("iter_cnt_dec", iter_cnt_o, e_cnt);
            end else begin
              chk("last_iter_cnt_zero", p_cnt, 0);
            end
          end
        end
      end
      if (iter_en_o && !(p_valid && p_iter)) begin
        chk("first_iter_digit", prev_quot_digit_o, 5'b00100);
        first_cnt = iter_cnt_o;
      end
      if (iter_en_o) iter_seen++;
      if (finish_valid_o && !(p_valid && p_fv)) begin
        if (!in_op || exp_q.size() == 0) begin
          chk("unexpected_finish", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("latency", cyc - hs_cyc, e.lat);
          chk("iterations", iter_seen, e.iters);
          chk("early_finish", early_finish_o, e.early);
          chk("div_by_zero", div_by_zero_o, e.dbz);
          chk("odd_shift", odd_shift_o, e.odd);
          if (e.early == 0) chk("iter_cnt_load", first_cnt, e.iters - 1);
          $display("op %0d: latency=%0d iters=%0d early=%0b dbz=%0b odd=%0b",
                   op_idx, cyc - hs_cyc, iter_seen, early_finish_o, div_by_zero_o, odd_shift_o);
          op_idx++;
        end
        in_op = 0;
      end
      if (start_valid_i && start_ready_o && !flush_i) begin
        in_op     = 1;
        hs_cyc    = cyc;
        iter_seen = 0;
      end
      p_valid  = 1;
      p_flush  = flush_i;
      p_fv     = finish_valid_o;
      p_fready = finish_ready_i;
      p_iter   = iter_en_o;
      p_cnt    = iter_cnt_o;
    end
  end

  // --------------------------------------------------------------- stimulus
  // One request. flush_at is the cycle after the handshake that carries
  // flush_i (0 = none); rdy_delay is how many DONE cycles pass before
  // finish_ready_i. Returns #1 after the edge that enters IDLE.
  task automatic run_op(input int dvd, input int dvs, input bit dz, input int flush_at,
                        input int rdy_delay, input bit use_dir);
    exp_t       e;
    logic [4:0] d;
    logic [4:0] dir_dig[3];
    int         k;
    dir_dig[0] = 5'b10000;
    dir_dig[1] = 5'b00010;
    dir_dig[2] = 5'b00100;
    k = 0;
    while (!start_ready_o && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    chk("wait_idle", start_ready_o, 1);
    if (!start_ready_o) begin
      flush_i = 1'b1;
      @(posedge clk); #1;
      flush_i = 1'b0;
    end
    e = model(dvd, dvs, dz);
    if (flush_at == 0 || flush_at >= e.lat) exp_q.push_back(e);
    start_valid_i  = 1'b1;
    dividend_lzc_i = LZC_W'(dvd);
    divisor_lzc_i  = LZC_W'(dvs);
    divisor_zero_i = dz;
    quot_digit_i   = rnd_digit();
    for (int r = 1; r < 200; r++) begin
      @(posedge clk); #1;
      start_valid_i  = 1'b0;
      flush_i        = 1'b0;
      finish_ready_i = 1'b0;
      if (e.early == 0 && r >= 3 && r <= e.iters + 2) begin
        d = (use_dir && (r - 3) < 3) ? dir_dig[r-3] : rnd_digit();
        quot_digit_i = d;
        if (flush_at == 0 || r < flush_at) dig_q.push_back(d);
      end else begin
        quot_digit_i = 5'($urandom);
      end
      if (r == flush_at) begin
        flush_i        = 1'b1;
        finish_ready_i = (r >= e.lat);
        @(posedge clk); #1;
        flush_i        = 1'b0;
        finish_ready_i = 1'b0;
        break;
      end
      if (r == e.lat + rdy_delay) begin
        finish_ready_i = 1'b1;
        @(posedge clk); #1;
        finish_ready_i = 1'b0;
        break;
      end
    end
  endtask

  initial begin : stimulus
    exp_t e;
    int   dvd, dvs, fa, gap;
    bit   dz;
    rst            = 1'b1;
    start_valid_i  = 1'b0;
    flush_i        = 1'b0;
    dividend_lzc_i = '0;
    divisor_lzc_i  = '0;
    divisor_zero_i = 1'b0;
    quot_digit_i   = '0;
    finish_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("por");
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(0, 31, 0, 0, 0, 0);   // 16 iterations, odd shift
    run_op(4, 4, 0, 0, 0, 0);    // single iteration
    run_op(0, 0, 1, 0, 1, 0);    // divide by zero
    run_op(10, 3, 0, 0, 0, 0);   // dividend smaller than divisor
    run_op(2, 6, 0, 0, 4, 1);    // digits +2,-1,0; result stalled 4 cycles
    run_op(0, 20, 0, 5, 0, 0);   // flush in third ITER cycle
    run_op(3, 9, 0, 9, 2, 0);    // flush in DONE together with finish_ready

    // flush and start request together in IDLE: flush wins
    start_valid_i = 1'b1;
    flush_i       = 1'b1;
    @(posedge clk); #1;
    start_valid_i = 1'b0;
    flush_i       = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 40; i++) begin
      dvd = $urandom_range(0, 31);
      dvs = ($urandom_range(0, 4) != 0) ? $urandom_range(dvd, 31) : $urandom_range(0, 31);
      dz  = ($urandom_range(0, 9) == 0);
      e   = model(dvd, dvs, dz);
      fa  = ($urandom_range(0, 9) == 0) ? $urandom_range(1, e.lat) : 0;
      run_op(dvd, dvs, dz, fa, $urandom_range(0, 3), 0);
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge clk); #1;
      end
    end

    // asynchronous reset while in PRE_1
    start_valid_i  = 1'b1;
    dividend_lzc_i = 5'd0;
    divisor_lzc_i  = 5'd31;
    divisor_zero_i = 1'b0;
    @(posedge clk); #1;
    start_valid_i = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check_reset_state("async_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_op(4, 4, 0, 0, 0, 0);
    run_op(0, 31, 0, 0, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("results_pending", exp_q.size(), 0);
    chk("digits_pending", dig_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
